pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline hazard, stall and exception controller for the five-stage core. Generates per-stage Stall and Flush for the IF/ID, ID/EX and EX/MEM pipeline registers and the PC unit. It resolves load-use hazards, memory and fetch wait states, ID-stage branch redirects, MEM-stage exceptions and exception return. It also holds the exception state registers EPC and Cause, and sits beside the decoder with combinational control paths into every pipeline register.

## Interface
- EXC_VECTOR, `WORD_ADDR_W'h0: word address of the exception handler.
- clk  in  1  core clock.
- reset_  in  1  asynchronous, active-low reset.
- IFBusy  in  1  instruction fetch not complete this cycle.
- MemBusy  in  1  MEM-stage bus access not complete this cycle.
- RaAddr, RbAddr  in  `REG_ADDR_BUS  source registers of the instruction in IF/ID.
- RaUse, RbUse  in  1  the matching source is actually read.
- IDEn, IDMemOp, IDDstAddr, IDGPRWE_  in  1/`MEM_OP_BUS/`REG_ADDR_BUS/1  ID/EX register contents.
- BrTaken  in  1  ID stage resolved a taken branch.
- BrTarget  in  `WORD_ADDR_BUS  branch target.
- MEMEn, MEMPC, MEMCtrlOp, MEMExpCode  in  1/`WORD_ADDR_BUS/`CTRL_OP_BUS/`ISA_EXP_BUS  EX/MEM register contents.
- IntReq  in  1  external interrupt request, level; present only with PIPE_CTRL_INT_EN.
- IFStall, IDStall, EXStall, MEMStall  out  1  hold the PC / IF/ID / ID/EX / EX/MEM register.
- IFFlush, IDFlush, EXFlush, MEMFlush  out  1  load a bubble into the same registers.
- PCLoad  out  1  PC takes NewPC at the next edge.
- NewPC  out  `WORD_ADDR_BUS  redirect target.
- EPC  out  `WORD_ADDR_BUS  saved PC of the faulting instruction.
- Cause  out  `ISA_EXP_BUS  saved exception code.
- ExcActive  out  1  a handler is running.
- Halt  out  1  double fault; the core is frozen.

## Operation
- State machine states:
  - RUN: normal operation.
  - EXC: handler active; ExcActive = 1.
  - HALT: terminal until reset.
- Request priority, highest first: Halt, MemBusy, MEM exception or ERET, load-use, branch, IFBusy.
- Halt: assert all Stall outputs; no flush, no PCLoad.
- MemBusy: assert all four Stall outputs; no flush. Exceptions and ERET are evaluated only when MemBusy = 0.
- MEM exception: MEMEn and MEMExpCode != `ISA_EXP_NO_EXP.
  - In RUN: assert all four Flush, PCLoad = 1, NewPC = EXC_VECTOR. At the edge, EPC <= MEMPC, Cause <= MEMExpCode, state -> EXC.
  - In EXC: state -> HALT, and EPC and Cause are overwritten with the second fault.
- ERET: MEMEn and MEMCtrlOp == `CTRL_OP_ERET.
  - In EXC: assert all Flush, PCLoad = 1, NewPC = EPC; state -> RUN.
  - In RUN: raises `ISA_EXP_UNDEF_INSN handling, i.e. the exception path above.
- Load-use hazard: IDEn, IDMemOp is a load, IDGPRWE_ == `ENABLE_, and IDDstAddr equals RaAddr with RaUse or RbAddr with RbUse. Assert IFStall and IDStall plus EXFlush (bubble) for exactly one cycle.
- Branch: BrTaken with no load-use hazard gives PCLoad = 1, NewPC = BrTarget, IDFlush = 1 (squash the fetched slot).
- IFBusy (lowest priority): IFStall = 1, IDFlush = 1.
- Stall overrides Flush for the same register; the two are never both asserted on one register.

## Timing
- All Stall, Flush, PCLoad and NewPC outputs are combinational from the current inputs and state; zero latency.
- EPC, Cause, ExcActive and Halt are registered and update at the clock edge following the event.
- Handler entry: first handler fetch starts the cycle after the exception is seen with MemBusy = 0.
- Reset values:
  - Combinational outputs: all Stall/Flush outputs and PCLoad = `DISABLE, NewPC = EXC_VECTOR.
  - Registered: EPC = 0, Cause = `ISA_EXP_NO_EXP, ExcActive = `DISABLE, Halt = `DISABLE, state RUN.
- Reset asserted mid-stall or mid-handler returns to the reset values immediately (asynchronous).
- Exception and branch in the same cycle: the exception wins and the branch is discarded.
- MemBusy held for N cycles stalls for exactly N cycles; a pending exception is taken in the first cycle with MemBusy = 0.

## Configuration
- PIPE_CTRL_INT_EN defined: IntReq port exists.
  - Takes effect in RUN with MemBusy = 0, no MEM exception, and MEMEn = 1.
  - Response is the exception path with Cause = `ISA_EXP_EXT_INT and EPC = MEMPC; the interrupted instruction is flushed and re-executed after ERET.
  - Ignored in EXC and HALT.
- PIPE_CTRL_INT_EN undefined: no IntReq port and no interrupt logic.

## Structure
- State encodings (PIPE_CTRL_RUN/EXC/HALT), `CTRL_OP_ERET and `ISA_EXP_EXT_INT belong in cpu.vh.
- Sub-module hazard_det: combinational load-use comparator with outputs LoadUse only.

## Test plan
- ID/EX holds a load to r3; IF/ID reads r3 via Ra -> one cycle IFStall = IDStall = EXFlush = 1, then all 0.
- MemBusy high for 3 cycles -> all Stall = 1 for exactly 3 cycles; no Flush, no PCLoad.
- MEMExpCode = overflow, MEMPC = 'h40 -> all Flush, PCLoad with NewPC = EXC_VECTOR; next cycle EPC = 'h40, ExcActive = 1.
- ERET reaches MEM while in EXC with EPC = 'h40 -> PCLoad, NewPC = 'h40, all Flush; next cycle ExcActive = 0.
- A second exception while in EXC -> Halt = 1 and all Stall held until reset_ pulses low.
- Exception and BrTaken (target 'h80) in the same cycle -> NewPC = EXC_VECTOR, never 'h80.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, encodings and FSM state type for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned MEM_OP_W    = 2;
    localparam int unsigned CTRL_OP_W   = 2;
    localparam int unsigned ISA_EXP_W   = 3;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
    typedef logic [MEM_OP_W-1:0]    mem_op_t;
    typedef logic [CTRL_OP_W-1:0]   ctrl_op_t;
    typedef logic [ISA_EXP_W-1:0]   isa_exp_t;

    localparam logic ENABLE   = 1'b1;
    localparam logic DISABLE  = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam mem_op_t MEM_OP_NOP = 2'd0;
    localparam mem_op_t MEM_OP_LDW = 2'd1;
    localparam mem_op_t MEM_OP_STW = 2'd2;

    localparam ctrl_op_t CTRL_OP_NOP  = 2'd0;
    localparam ctrl_op_t CTRL_OP_WRCR = 2'd1;
    localparam ctrl_op_t CTRL_OP_ERET = 2'd2;

    localparam isa_exp_t ISA_EXP_NO_EXP     = 3'd0;
    localparam isa_exp_t ISA_EXP_EXT_INT    = 3'd1;
    localparam isa_exp_t ISA_EXP_UNDEF_INSN = 3'd2;
    localparam isa_exp_t ISA_EXP_OVERFLOW   = 3'd3;
    localparam isa_exp_t ISA_EXP_MISS_ALIGN = 3'd4;

    localparam word_addr_t EXC_VECTOR = '0;

    typedef enum logic [1:0] {
        PIPE_CTRL_RUN  = 2'd0,
        PIPE_CTRL_EXC  = 2'd1,
        PIPE_CTRL_HALT = 2'd2
    } state_e;

    function automatic logic is_load(input mem_op_t op);
        return op == MEM_OP_LDW;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline registers and pipe_ctrl.
// IntReq exists only when PIPE_CTRL_INT_EN is defined.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic       IFBusy;
    logic       MemBusy;
    reg_addr_t  RaAddr;
    reg_addr_t  RbAddr;
    logic       RaUse;
    logic       RbUse;
    logic       IDEn;
    mem_op_t    IDMemOp;
    reg_addr_t  IDDstAddr;
    logic       IDGPRWE_;
    logic       BrTaken;
    word_addr_t BrTarget;
    logic       MEMEn;
    word_addr_t MEMPC;
    ctrl_op_t   MEMCtrlOp;
    isa_exp_t   MEMExpCode;
`ifdef PIPE_CTRL_INT_EN
    logic       IntReq;
`endif
    logic       IFStall;
    logic       IDStall;
    logic       EXStall;
    logic       MEMStall;
    logic       IFFlush;
    logic       IDFlush;
    logic       EXFlush;
    logic       MEMFlush;
    logic       PCLoad;
    word_addr_t NewPC;
    word_addr_t EPC;
    isa_exp_t   Cause;
    logic       ExcActive;
    logic       Halt;

    modport master (
`ifdef PIPE_CTRL_INT_EN
        output IntReq,
`endif
        output IFBusy, MemBusy, RaAddr, RbAddr, RaUse, RbUse,
        output IDEn, IDMemOp, IDDstAddr, IDGPRWE_, BrTaken, BrTarget,
        output MEMEn, MEMPC, MEMCtrlOp, MEMExpCode,
        input  IFStall, IDStall, EXStall, MEMStall,
        input  IFFlush, IDFlush, EXFlush, MEMFlush,
        input  PCLoad, NewPC, EPC, Cause, ExcActive, Halt
    );

    modport slave (
`ifdef PIPE_CTRL_INT_EN
        input  IntReq,
`endif
        input  IFBusy, MemBusy, RaAddr, RbAddr, RaUse, RbUse,
        input  IDEn, IDMemOp, IDDstAddr, IDGPRWE_, BrTaken, BrTarget,
        input  MEMEn, MEMPC, MEMCtrlOp, MEMExpCode,
        output IFStall, IDStall, EXStall, MEMStall,
        output IFFlush, IDFlush, EXFlush, MEMFlush,
        output PCLoad, NewPC, EPC, Cause, ExcActive, Halt
    );

endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use comparator: the load sitting in ID/EX writes a register the IF/ID instruction reads.
module hazard_det
    import pipe_ctrl_pkg::*;
(
    input  reg_addr_t RaAddr,
    input  reg_addr_t RbAddr,
    input  logic      RaUse,
    input  logic      RbUse,
    input  logic      IDEn,
    input  mem_op_t   IDMemOp,
    input  reg_addr_t IDDstAddr,
    input  logic      IDGPRWE_,
    output logic      LoadUse
);

    logic ra_hit;
    logic rb_hit;

    always_comb begin
        ra_hit  = RaUse && (RaAddr == IDDstAddr);
        rb_hit  = RbUse && (RbAddr == IDDstAddr);
        LoadUse = IDEn && is_load(IDMemOp) && (IDGPRWE_ == ENABLE_) && (ra_hit || rb_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller with EPC/Cause exception state.
// Optional external interrupt input enabled by defining PIPE_CTRL_INT_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input logic       clk,
    input logic       reset_,
    pipe_ctrl_if.slave bus
);

    state_e     state_q, state_d;
    word_addr_t epc_q, epc_d;
    isa_exp_t   cause_q, cause_d;

    // Bit order {IF, ID, EX, MEM}
    logic [3:0] stall;
    logic [3:0] flush;
    logic       pc_load;
    word_addr_t new_pc;

    logic       load_use;
    logic       mem_exc;
    logic       eret;
    logic       int_req;
    isa_exp_t   trap_cause;

    hazard_det u_hazard_det (
        .RaAddr    (bus.RaAddr),
        .RbAddr    (bus.RbAddr),
        .RaUse     (bus.RaUse),
        .RbUse     (bus.RbUse),
        .IDEn      (bus.IDEn),
        .IDMemOp   (bus.IDMemOp),
        .IDDstAddr (bus.IDDstAddr),
        .IDGPRWE_  (bus.IDGPRWE_),
        .LoadUse   (load_use)
    );

`ifdef PIPE_CTRL_INT_EN
    assign int_req = bus.IntReq && bus.MEMEn && (state_q == PIPE_CTRL_RUN);
`else
    assign int_req = 1'b0;
`endif

    assign mem_exc = bus.MEMEn && (bus.MEMExpCode != ISA_EXP_NO_EXP);
    assign eret    = bus.MEMEn && (bus.MEMCtrlOp == CTRL_OP_ERET);

    // ERET outside a handler is an illegal instruction; interrupts rank below real faults.
    always_comb begin
        if (mem_exc)
            trap_cause = bus.MEMExpCode;
        else if (eret)
            trap_cause = ISA_EXP_UNDEF_INSN;
        else
            trap_cause = ISA_EXP_EXT_INT;
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        stall   = '0;
        flush   = '0;
        pc_load = DISABLE;
        new_pc  = EXC_VECTOR;

        if (state_q == PIPE_CTRL_HALT) begin
            stall = '1;
        end else if (bus.MemBusy) begin
            stall = '1;
        end else if (mem_exc || eret || int_req) begin
            if (state_q == PIPE_CTRL_EXC) begin
                if (mem_exc) begin
                    flush   = '1;
                    epc_d   = bus.MEMPC;
                    cause_d = bus.MEMExpCode;
                    state_d = PIPE_CTRL_HALT;
                end else begin
                    flush   = '1;
                    pc_load = ENABLE;
                    new_pc  = epc_q;
                    state_d = PIPE_CTRL_RUN;
                end
            end else begin
                flush   = '1;
                pc_load = ENABLE;
                new_pc  = EXC_VECTOR;
                epc_d   = bus.MEMPC;
                cause_d = trap_cause;
                state_d = PIPE_CTRL_EXC;
            end
        end else if (load_use) begin
            stall = 4'b1100;
            flush = 4'b0010;
        end else if (bus.BrTaken) begin
            pc_load = ENABLE;
            new_pc  = bus.BrTarget;
            flush   = 4'b0100;
        end else if (bus.IFBusy) begin
            stall = 4'b1000;
            flush = 4'b0100;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= PIPE_CTRL_RUN;
            epc_q   <= '0;
            cause_q <= ISA_EXP_NO_EXP;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    assign bus.IFStall   = stall[3];
    assign bus.IDStall   = stall[2];
    assign bus.EXStall   = stall[1];
    assign bus.MEMStall  = stall[0];
    assign bus.IFFlush   = flush[3] & ~stall[3];
    assign bus.IDFlush   = flush[2] & ~stall[2];
    assign bus.EXFlush   = flush[1] & ~stall[1];
    assign bus.MEMFlush  = flush[0] & ~stall[0];
    assign bus.PCLoad    = pc_load;
    assign bus.NewPC     = new_pc;
    assign bus.EPC       = epc_q;
    assign bus.Cause     = cause_q;
    assign bus.ExcActive = (state_q == PIPE_CTRL_EXC);
    assign bus.Halt      = (state_q == PIPE_CTRL_HALT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for combinational decisions, sequences for exception flow.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk;
    logic reset_;
    int   tests;
    int   fails;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IFStall, IDStall, EXStall, MEMStall, IFFlush, IDFlush, EXFlush, MEMFlush, PCLoad}
    logic [8:0] ctl;
    assign ctl = {bus.IFStall, bus.IDStall, bus.EXStall, bus.MEMStall,
                  bus.IFFlush, bus.IDFlush, bus.EXFlush, bus.MEMFlush, bus.PCLoad};

    localparam logic [8:0] C_NONE  = 9'b000000000;
    localparam logic [8:0] C_LU    = 9'b110000100;
    localparam logic [8:0] C_BR    = 9'b000001001;
    localparam logic [8:0] C_IFB   = 9'b100001000;
    localparam logic [8:0] C_STALL = 9'b111100000;
    localparam logic [8:0] C_EXC   = 9'b000011111;

    typedef struct packed {
        logic       ifb;
        logic       memb;
        reg_addr_t  ra;
        logic       ra_use;
        reg_addr_t  rb;
        logic       rb_use;
        logic       id_en;
        mem_op_t    memop;
        reg_addr_t  dst;
        logic       we_n;
        logic       br;
        word_addr_t tgt;
        logic [8:0] exp_ctl;
        word_addr_t exp_pc;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mkv(input logic ifb, input logic memb,
                                 input reg_addr_t ra, input logic ra_use,
                                 input reg_addr_t rb, input logic rb_use,
                                 input logic id_en, input mem_op_t memop,
                                 input reg_addr_t dst, input logic we_n,
                                 input logic br, input word_addr_t tgt,
                                 input logic [8:0] exp_ctl, input word_addr_t exp_pc);
        vec_t v;
        v = '{ifb, memb, ra, ra_use, rb, rb_use, id_en, memop, dst, we_n, br, tgt, exp_ctl, exp_pc};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic clr();
        bus.IFBusy     = 1'b0;
        bus.MemBusy    = 1'b0;
        bus.RaAddr     = '0;
        bus.RbAddr     = '0;
        bus.RaUse      = 1'b0;
        bus.RbUse      = 1'b0;
        bus.IDEn       = 1'b0;
        bus.IDMemOp    = MEM_OP_NOP;
        bus.IDDstAddr  = '0;
        bus.IDGPRWE_   = DISABLE_;
        bus.BrTaken    = 1'b0;
        bus.BrTarget   = '0;
        bus.MEMEn      = 1'b0;
        bus.MEMPC      = '0;
        bus.MEMCtrlOp  = CTRL_OP_NOP;
        bus.MEMExpCode = ISA_EXP_NO_EXP;
`ifdef PIPE_CTRL_INT_EN
        bus.IntReq     = 1'b0;
`endif
    endtask

    task automatic apply(input vec_t v);
        bus.IFBusy    = v.ifb;
        bus.MemBusy   = v.memb;
        bus.RaAddr    = v.ra;
        bus.RaUse     = v.ra_use;
        bus.RbAddr    = v.rb;
        bus.RbUse     = v.rb_use;
        bus.IDEn      = v.id_en;
        bus.IDMemOp   = v.memop;
        bus.IDDstAddr = v.dst;
        bus.IDGPRWE_  = v.we_n;
        bus.BrTaken   = v.br;
        bus.BrTarget  = v.tgt;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset_ = 1'b0;
        clr();

        vecs[0]  = mkv(0, 0, 3, 0, 4, 0, 0, MEM_OP_NOP, 0, 1, 0, 30'h0,  C_NONE,  30'h0);
        vecs[1]  = mkv(0, 0, 3, 1, 4, 0, 1, MEM_OP_LDW, 3, 0, 0, 30'h0,  C_LU,    30'h0);
        vecs[2]  = mkv(0, 0, 7, 0, 3, 1, 1, MEM_OP_LDW, 3, 0, 0, 30'h0,  C_LU,    30'h0);
        vecs[3]  = mkv(0, 0, 3, 0, 4, 1, 1, MEM_OP_LDW, 3, 0, 0, 30'h0,  C_NONE,  30'h0);
        vecs[4]  = mkv(0, 0, 3, 1, 4, 0, 1, MEM_OP_LDW, 3, 1, 0, 30'h0,  C_NONE,  30'h0);
        vecs[5]  = mkv(0, 0, 3, 1, 4, 0, 1, MEM_OP_STW, 3, 0, 0, 30'h0,  C_NONE,  30'h0);
        vecs[6]  = mkv(0, 0, 3, 1, 4, 0, 0, MEM_OP_LDW, 3, 0, 0, 30'h0,  C_NONE,  30'h0);
        vecs[7]  = mkv(0, 0, 3, 1, 4, 0, 0, MEM_OP_NOP, 0, 1, 1, 30'h80, C_BR,    30'h80);
        vecs[8]  = mkv(0, 0, 3, 1, 4, 0, 1, MEM_OP_LDW, 3, 0, 1, 30'h80, C_LU,    30'h0);
        vecs[9]  = mkv(1, 0, 0, 0, 0, 0, 0, MEM_OP_NOP, 0, 1, 0, 30'h0,  C_IFB,   30'h0);
        vecs[10] = mkv(1, 0, 0, 0, 0, 0, 0, MEM_OP_NOP, 0, 1, 1, 30'h90, C_BR,    30'h90);
        vecs[11] = mkv(0, 1, 0, 0, 0, 0, 0, MEM_OP_NOP, 0, 1, 0, 30'h0,  C_STALL, 30'h0);
        vecs[12] = mkv(0, 1, 3, 1, 4, 0, 1, MEM_OP_LDW, 3, 0, 1, 30'h80, C_STALL, 30'h0);
        vecs[13] = mkv(1, 0, 3, 1, 4, 0, 1, MEM_OP_LDW, 3, 0, 0, 30'h0,  C_LU,    30'h0);

        // Reset state
        #2;
        chk("reset ctl", 32'(ctl), 32'(C_NONE));
        chk("reset NewPC", 32'(bus.NewPC), 32'(EXC_VECTOR));
        chk("reset EPC", 32'(bus.EPC), 32'h0);
        chk("reset Cause", 32'(bus.Cause), 32'(ISA_EXP_NO_EXP));
        chk("reset ExcActive", 32'(bus.ExcActive), 32'h0);
        chk("reset Halt", 32'(bus.Halt), 32'h0);
        @(negedge clk);
        reset_ = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d ctl", i), 32'(ctl), 32'(vecs[i].exp_ctl));
            chk($sformatf("vec%0d NewPC", i), 32'(bus.NewPC), 32'(vecs[i].exp_pc));
        end
        chk("table ExcActive", 32'(bus.ExcActive), 32'h0);

        // Load-use lasts one cycle: the load moves on and ID/EX holds the bubble
        @(negedge clk);
        clr();
        bus.RaAddr = 5'd3; bus.RaUse = 1'b1;
        bus.IDEn = 1'b1; bus.IDMemOp = MEM_OP_LDW; bus.IDDstAddr = 5'd3; bus.IDGPRWE_ = ENABLE_;
        #1 chk("lu cycle1", 32'(ctl), 32'(C_LU));
        @(negedge clk);
        bus.IDEn = 1'b0;
        #1 chk("lu cycle2", 32'(ctl), 32'(C_NONE));

        // Pending overflow held off by MemBusy for 3 cycles, then wins over a branch
        @(negedge clk);
        clr();
        bus.MEMEn = 1'b1; bus.MEMExpCode = ISA_EXP_OVERFLOW; bus.MEMPC = 30'h40; bus.MemBusy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk($sformatf("membusy%0d ctl", c), 32'(ctl), 32'(C_STALL));
            chk($sformatf("membusy%0d ExcActive", c), 32'(bus.ExcActive), 32'h0);
        end
        @(negedge clk);
        bus.MemBusy = 1'b0; bus.BrTaken = 1'b1; bus.BrTarget = 30'h80;
        #1;
        chk("exc ctl", 32'(ctl), 32'(C_EXC));
        chk("exc NewPC", 32'(bus.NewPC), 32'(EXC_VECTOR));
        @(negedge clk);
        clr();
        #1;
        chk("exc EPC", 32'(bus.EPC), 32'h40);
        chk("exc Cause", 32'(bus.Cause), 32'(ISA_EXP_OVERFLOW));
        chk("exc ExcActive", 32'(bus.ExcActive), 32'h1);
        chk("exc idle ctl", 32'(ctl), 32'(C_NONE));

        // ERET inside handler
        @(negedge clk);
        bus.MEMEn = 1'b1; bus.MEMCtrlOp = CTRL_OP_ERET;
        #1;
        chk("eret ctl", 32'(ctl), 32'(C_EXC));
        chk("eret NewPC", 32'(bus.NewPC), 32'h40);
        @(negedge clk);
        clr();
        #1;
        chk("eret ExcActive", 32'(bus.ExcActive), 32'h0);
        chk("eret EPC kept", 32'(bus.EPC), 32'h40);

        // ERET outside handler traps as undefined instruction
        @(negedge clk);
        bus.MEMEn = 1'b1; bus.MEMCtrlOp = CTRL_OP_ERET; bus.MEMPC = 30'h50;
        #1;
        chk("bad eret ctl", 32'(ctl), 32'(C_EXC));
        chk("bad eret NewPC", 32'(bus.NewPC), 32'(EXC_VECTOR));
        @(negedge clk);
        clr();
        #1;
        chk("bad eret Cause", 32'(bus.Cause), 32'(ISA_EXP_UNDEF_INSN));
        chk("bad eret EPC", 32'(bus.EPC), 32'h50);
        chk("bad eret ExcActive", 32'(bus.ExcActive), 32'h1);

        // Double fault freezes the core
        @(negedge clk);
        bus.MEMEn = 1'b1; bus.MEMExpCode = ISA_EXP_MISS_ALIGN; bus.MEMPC = 30'h60;
        @(negedge clk);
        clr();
        bus.BrTaken = 1'b1; bus.BrTarget = 30'h80;
        #1;
        chk("halt Halt", 32'(bus.Halt), 32'h1);
        chk("halt EPC", 32'(bus.EPC), 32'h60);
        chk("halt Cause", 32'(bus.Cause), 32'(ISA_EXP_MISS_ALIGN));
        chk("halt ctl", 32'(ctl), 32'(C_STALL));
        @(negedge clk);
        bus.BrTaken = 1'b0; bus.IFBusy = 1'b1;
        bus.MEMEn = 1'b1; bus.MEMCtrlOp = CTRL_OP_ERET;
        #1;
        chk("halt held ctl", 32'(ctl), 32'(C_STALL));
        chk("halt held Halt", 32'(bus.Halt), 32'h1);

        // Asynchronous reset mid-halt
        #2;
        clr();
        reset_ = 1'b0;
        #1;
        chk("areset Halt", 32'(bus.Halt), 32'h0);
        chk("areset EPC", 32'(bus.EPC), 32'h0);
        chk("areset Cause", 32'(bus.Cause), 32'(ISA_EXP_NO_EXP));
        chk("areset ctl", 32'(ctl), 32'(C_NONE));
        chk("areset NewPC", 32'(bus.NewPC), 32'(EXC_VECTOR));
        @(negedge clk);
        reset_ = 1'b1;

        // Asynchronous reset mid-handler
        @(negedge clk);
        bus.MEMEn = 1'b1; bus.MEMExpCode = ISA_EXP_OVERFLOW; bus.MEMPC = 30'h70;
        @(negedge clk);
        clr();
        #1 chk("handler ExcActive", 32'(bus.ExcActive), 32'h1);
        #2;
        reset_ = 1'b0;
        #1;
        chk("areset2 ExcActive", 32'(bus.ExcActive), 32'h0);
        chk("areset2 EPC", 32'(bus.EPC), 32'h0);
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
